// File: rtl/npu_lane_stream_if.sv
// Stream bundle for npu_lane_stream: input FIFO read side, NPU operand/result
// channels and output FIFO write side. The stage uses the slave modport.
interface npu_lane_stream_if #(
  parameter int ACP_WIDTH  = 64,
  parameter int LANE_WIDTH = 32
);
  logic [ACP_WIDTH-1:0]  in_data;
  logic                  in_empty_n;
  logic                  in_deq;
  logic [LANE_WIDTH-1:0] npu_in_data;
  logic                  npu_in_valid;
  logic                  npu_in_ready;
  logic [LANE_WIDTH-1:0] npu_out_data;
  logic                  npu_out_valid;
  logic                  npu_out_ready;
  logic [ACP_WIDTH-1:0]  out_data;
  logic                  out_enq;
  logic                  out_full_n;

  modport slave (
    input  in_data, in_empty_n, npu_in_ready, npu_out_data, npu_out_valid, out_full_n,
    output in_deq, npu_in_data, npu_in_valid, npu_out_ready, out_data, out_enq
  );

  modport master (
    output in_data, in_empty_n, npu_in_ready, npu_out_data, npu_out_valid, out_full_n,
    input  in_deq, npu_in_data, npu_in_valid, npu_out_ready, out_data, out_enq
  );
endinterface

// File: rtl/npu_lane_stream.sv
// Splits ACP words into NPU lane operands and repacks NPU results into ACP words.
// Define STREAM_BYPASS_EN to route input words straight to the output FIFO.
module npu_lane_stream #(
  parameter int ACP_WIDTH  = 64,
  parameter int LANE_WIDTH = 32,
  parameter int BATCH_SIZE = 128,
  parameter int CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  npu_lane_stream_if.slave  strm,
  output logic              batch_done_o,
  output logic [CNT_W-1:0]  in_count_o,
  output logic [CNT_W-1:0]  out_count_o,
  output logic              busy_o
);
  localparam int LANES = ACP_WIDTH / LANE_WIDTH;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BATCH_SIZE - 1);

  typedef enum logic {P_FILL, P_FLUSH} packState_e;

  packState_e           state_q, state_d;
  logic                 holdValid_q, holdValid_d;
  logic [ACP_WIDTH-1:0] hold_q, hold_d;
  logic [IDX_W-1:0]     laneIdx_q, laneIdx_d;
  logic [ACP_WIDTH-1:0] pack_q, pack_d;
  logic [IDX_W-1:0]     packIdx_q, packIdx_d;
  logic [ACP_WIDTH-1:0] outData_q, outData_d;
  logic                 outEnq_q, outEnq_d;
  logic                 batchDone_q, batchDone_d;
  logic [CNT_W-1:0]     inCount_q, inCount_d;
  logic [CNT_W-1:0]     outCount_q, outCount_d;
  logic                 inDeq;
  logic                 outHs;

`ifdef STREAM_BYPASS_EN
  always_comb begin
    inDeq              = !rst_i && strm.in_empty_n && (state_q == P_FILL);
    holdValid_d        = 1'b0;
    hold_d             = '0;
    laneIdx_d          = '0;
    strm.npu_in_valid  = 1'b0;
    strm.npu_in_data   = '0;
    strm.npu_out_ready = 1'b0;
    outHs              = 1'b0;
  end
`else
  // A last-lane handshake may reload the hold register in the same cycle.
  always_comb begin
    logic inHs;
    logic lastLane;
    inHs               = holdValid_q && strm.npu_in_ready;
    lastLane           = (laneIdx_q == LAST_IDX);
    inDeq              = !rst_i && strm.in_empty_n && (!holdValid_q || (inHs && lastLane));
    holdValid_d        = holdValid_q;
    hold_d             = hold_q;
    laneIdx_d          = laneIdx_q;
    if (inHs) begin
      if (lastLane) begin
        holdValid_d = 1'b0;
        laneIdx_d   = '0;
      end else begin
        laneIdx_d   = laneIdx_q + 1'b1;
      end
    end
    if (inDeq) begin
      holdValid_d = 1'b1;
      hold_d      = strm.in_data;
      laneIdx_d   = '0;
    end
    strm.npu_in_valid  = holdValid_q;
    strm.npu_in_data   = hold_q[laneIdx_q*LANE_WIDTH +: LANE_WIDTH];
    strm.npu_out_ready = !rst_i && (state_q == P_FILL);
    outHs              = strm.npu_out_valid && strm.npu_out_ready;
  end
`endif

  always_comb begin
    state_d     = state_q;
    pack_d      = pack_q;
    packIdx_d   = packIdx_q;
    outData_d   = outData_q;
    outEnq_d    = 1'b0;
    batchDone_d = 1'b0;
    inCount_d   = inCount_q;
    outCount_d  = outCount_q;
    case (state_q)
      P_FILL: begin
`ifdef STREAM_BYPASS_EN
        if (inDeq) begin
          pack_d  = strm.in_data;
          state_d = P_FLUSH;
        end
`else
        if (outHs) begin
          pack_d[packIdx_q*LANE_WIDTH +: LANE_WIDTH] = strm.npu_out_data;
          if (packIdx_q == LAST_IDX) begin
            state_d = P_FLUSH;
          end else begin
            packIdx_d = packIdx_q + 1'b1;
          end
        end
`endif
      end
      P_FLUSH: begin
        if (strm.out_full_n) begin
          outData_d = pack_q;
          outEnq_d  = 1'b1;
          packIdx_d = '0;
          state_d   = P_FILL;
        end
      end
      default: state_d = P_FILL;
    endcase
    if (inDeq) begin
      inCount_d = (inCount_q == LAST_CNT) ? '0 : inCount_q + 1'b1;
    end
    // The counter and batch_done update on the same edge that raises out_enq.
    if (outEnq_d) begin
      if (outCount_q == LAST_CNT) begin
        outCount_d  = '0;
        batchDone_d = 1'b1;
      end else begin
        outCount_d  = outCount_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= P_FILL;
      holdValid_q <= 1'b0;
      hold_q      <= '0;
      laneIdx_q   <= '0;
      pack_q      <= '0;
      packIdx_q   <= '0;
      outData_q   <= '0;
      outEnq_q    <= 1'b0;
      batchDone_q <= 1'b0;
      inCount_q   <= '0;
      outCount_q  <= '0;
    end else begin
      state_q     <= state_d;
      holdValid_q <= holdValid_d;
      hold_q      <= hold_d;
      laneIdx_q   <= laneIdx_d;
      pack_q      <= pack_d;
      packIdx_q   <= packIdx_d;
      outData_q   <= outData_d;
      outEnq_q    <= outEnq_d;
      batchDone_q <= batchDone_d;
      inCount_q   <= inCount_d;
      outCount_q  <= outCount_d;
    end
  end

  assign strm.in_deq   = inDeq;
  assign strm.out_data = outData_q;
  assign strm.out_enq  = outEnq_q;
  assign batch_done_o  = batchDone_q;
  assign in_count_o    = inCount_q;
  assign out_count_o   = outCount_q;
  assign busy_o        = holdValid_q || (packIdx_q != '0) || (state_q == P_FLUSH)
                         || (inCount_q != outCount_q);
endmodule

// File: doc/npu_lane_stream.md
# npu_lane_stream

Streaming stage between the ACP input BRAMFIFO and the output BRAMFIFO that feeds the AXI write engine. It dequeues ACP_WIDTH words from the input FIFO and splits each into LANE_WIDTH operands for the NPU over a valid/ready port. It packs the NPU results back into ACP_WIDTH words, enqueues them to the output FIFO, and flags batch completion every BATCH_SIZE output words.

## Interface
- ACP_WIDTH, 64: FIFO/ACP word width
- LANE_WIDTH, 32: NPU operand/result width; ACP_WIDTH must be an integer multiple; LANES = ACP_WIDTH/LANE_WIDTH
- BATCH_SIZE, 128: ACP words per batch
- CNT_W, 16: width of batch counters
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- in_data  in  ACP_WIDTH  input FIFO D_OUT, first-word fall-through, valid while in_empty_n
- in_empty_n  in  1  input FIFO non-empty
- in_deq  out  1  combinational; dequeue input FIFO this cycle
- npu_in_data  out  LANE_WIDTH  operand to NPU
- npu_in_valid  out  1  operand valid
- npu_in_ready  in  1  NPU accepts operand
- npu_out_data  in  LANE_WIDTH  NPU result
- npu_out_valid  in  1  result valid
- npu_out_ready  out  1  combinational; stage accepts result
- out_data  out  ACP_WIDTH  packed word to output FIFO D_IN, registered
- out_enq  out  1  registered one-cycle enqueue pulse
- out_full_n  in  1  output FIFO not full
- batch_done  out  1  registered pulse, coincident with the BATCH_SIZE-th out_enq
- in_count  out  CNT_W  words dequeued in current batch
- out_count  out  CNT_W  words enqueued in current batch
- busy  out  1  any word or lane in flight

## Operation
- Unpacker: hold register plus lane index. When the hold register is empty and in_empty_n is high, assert in_deq and capture in_data.
- Lane k is in_data[k*LANE_WIDTH +: LANE_WIDTH]; lane 0 is presented first.
- npu_in_valid is high while the hold register is valid. Data stays stable and valid is never withdrawn until npu_in_ready.
- Each npu_in handshake increments the lane index.
- On the last-lane handshake, if in_empty_n is high, in_deq reloads the hold register in the same cycle. There is no bubble.
- in_count increments on in_deq and wraps from BATCH_SIZE-1 to 0.
- Packer states:
  - P_FILL: npu_out_ready=1. Each npu_out handshake writes the result into lane pack_idx and increments pack_idx. The last lane moves to P_FLUSH.
  - P_FLUSH: npu_out_ready=0. When out_full_n is high, on the next edge out_data<=pack, out_enq<=1, pack_idx<=0, return to P_FILL. When out_full_n is low, stay in P_FLUSH.
- out_count increments on each out_enq. At BATCH_SIZE-1 it wraps to 0 and batch_done pulses on the same cycle as out_enq.
- busy = hold valid | pack_idx!=0 | P_FLUSH | (in_count!=out_count).
- Counters are CNT_W-bit unsigned. BATCH_SIZE must be <= 2^CNT_W.

## Timing
- Reset values: all outputs 0, state P_FILL, hold invalid, indices 0. in_deq=0 and npu_out_ready=0 while RST is high.
- in_data to npu_in_valid: 1 cycle after in_deq.
- Last result accepted (edge k) to out_enq high: cycle after edge k+1 if out_full_n is high.
- Unpacker and packer run independently. An npu_in and an npu_out handshake in the same cycle are both honoured.
- Reset mid-operation discards the partial hold and pack words with no out_enq. Both FIFOs are cleared by their own reset.
- out_full_n low exerts back-pressure on the NPU only; dequeuing continues until the unpacker blocks on npu_in_ready.

## Configuration
- STREAM_BYPASS_EN defined: NPU bypassed.
  - npu_in_valid=0 and npu_out_ready=0 constantly.
  - In P_FILL with in_empty_n high, assert in_deq, load pack with in_data unchanged, go to P_FLUSH.
  - Throughput is one word per 2 cycles. Counters and batch_done behave identically.
- Undefined: full lane path through the NPU as above.

## Test plan
- Identity-ready NPU, input 0x00000002_00000001: npu_in_data 0x1 then 0x2. Returning 0xA then 0xB gives out_data 0x0000000B_0000000A and exactly one out_enq.
- npu_in_ready low for 5 cycles after the first word: npu_in_valid held, data 0x1 stable, in_deq=0 with 2 words queued.
- out_full_n low during P_FLUSH for 4 cycles: npu_out_ready=0, no out_enq. out_enq follows 1 cycle after out_full_n rises.
- BATCH_SIZE=4, 8 words streamed: batch_done pulses on the 4th and 8th out_enq, out_count returns to 0, busy=0 at end.
- RST asserted after lane 0 accepted: next cycle all outputs 0 and busy=0. A following word is processed from lane 0 correctly.
- STREAM_BYPASS_EN build, input 0xDEADBEEF_01234567: out_data is identical, npu_in_valid and npu_out_ready stay 0.
